uart_resp_encode: RTL and testbench
===================================

Name: uart_resp_encode

Overview:
- Transmit-side counterpart of the UART command decoder in the UART/SDRAM bridge.
- After an SDRAM read burst has filled the read FIFO, this block drains SEND_NUM bytes from the read FIFO and feeds them one at a time to the UART transmitter.
- It paces each byte on the transmitter's tx_done.
- It optionally sends a response header byte before the payload.

Parameters:
- SEND_NUM, 4, payload bytes per response frame; legal range 1..255.
- HDR_BYTE, 8'hAA, header byte value, used only when RESP_HEADER_EN is defined.

Ports:
- clk  input  1  system clock
- rst  input  1  asynchronous, active-high reset
- rd_done  input  1  single-cycle pulse: SDRAM read burst complete, payload present in read FIFO
- rfifo_empty  input  1  read FIFO empty flag
- rfifo_data  input  8  read FIFO output data; valid one cycle after rfifo_rd_en (normal mode, not show-ahead)
- rfifo_rd_en  output  1  read FIFO pop strobe, one cycle per byte
- tx_done  input  1  single-cycle pulse from UART TX: current byte fully shifted out (stop bit done)
- tx_start  output  1  single-cycle pulse: UART TX loads tx_data
- tx_data  output  8  byte presented to UART TX; held stable from tx_start until the next tx_start
- busy  output  1  high while a frame is in progress (any state other than IDLE)
- frame_done  output  1  single-cycle pulse after the last payload byte's tx_done

Behaviour:
- Reset: state=IDLE, byte counter=0, pending=0. All outputs 0: rfifo_rd_en, tx_start, tx_data, busy, frame_done.
- All outputs are registered.
- Byte counter: 8 bits. Cleared on entry to IDLE. Incremented on each payload tx_done accepted in WAIT.
- State machine:
  - IDLE: on rd_done or pending=1, clear pending. Go to HDR if RESP_HEADER_EN is defined, else go to FETCH.
  - HDR: tx_data<=HDR_BYTE, tx_start pulses 1 cycle, go to HWAIT.
  - HWAIT: on tx_done, go to FETCH.
  - FETCH: if rfifo_empty=0, rfifo_rd_en pulses 1 cycle, go to LATCH. If empty, stay in FETCH with rd_en low; no timeout.
  - LATCH: one cycle. tx_data<=rfifo_data, tx_start pulses, go to WAIT.
  - WAIT: on tx_done, counter+1. If the counter (pre-increment) equals SEND_NUM-1, go to DONE. Otherwise go to FETCH.
  - DONE: frame_done pulses 1 cycle, go to IDLE.
- Timing: from rd_done with a non-empty FIFO and no header, rfifo_rd_en asserts 2 cycles later and tx_start 3 cycles later. After each tx_done, the next tx_start follows 3 cycles later if the FIFO is non-empty.
- tx_done is honoured only in HWAIT/WAIT; ignored in every other state.
- rd_done outside IDLE sets pending (one deep). Further rd_done while pending=1 is dropped. A pending request starts a new frame on the cycle after DONE.
- rd_done in the same cycle as the DONE->IDLE transition is captured as pending.
- rfifo_rd_en is never asserted while rfifo_empty=1. Bytes remaining in the FIFO after a frame are not touched.
- Reset mid-frame: immediate return to reset values. Pending request lost. No partial frame_done.

Optional Feature:
- Macro RESP_HEADER_EN.
- When defined: every frame starts with HDR_BYTE, and the frame is SEND_NUM+1 bytes on the UART. frame_done timing is counted on payload bytes only.
- When undefined: HDR/HWAIT states are not built, the frame is exactly SEND_NUM payload bytes, and IDLE goes directly to FETCH.

Test Plan:
- Basic frame, SEND_NUM=4, no header: FIFO holds 11,22,33,44; rd_done pulse; model TX returns tx_done 10 cycles after each tx_start. Required: four tx_start pulses with tx_data 11,22,33,44 in order; exactly four rfifo_rd_en pulses; one frame_done after the 4th tx_done; busy low afterwards.
- Header enabled, RESP_HEADER_EN defined, same data: required tx_data sequence AA,11,22,33,44; no rfifo_rd_en before the header's tx_done; one frame_done.
- FIFO underflow: FIFO holds 11,22 only, then 33,44 pushed 50 cycles later. Required: block stalls in FETCH with rfifo_rd_en low while empty; resumes and sends 33,44; frame_done once.
- Back-to-back request: second rd_done pulse during byte 2 of frame 1, then a third rd_done also mid-frame. Required: exactly two frames sent (8 bytes), third request dropped; frame 2's first tx_start 3 cycles after frame 1's frame_done+1.
- Stray tx_done: tx_done pulses while in IDLE and FETCH. Required: counter unchanged; byte count per frame stays 4.
- Reset mid-frame: assert rst after the 2nd tx_start. Required: all outputs 0 immediately; busy=0; no frame_done; the next rd_done starts a fresh 4-byte frame from counter 0.

Source files
------------

// File: rtl/uart_resp_encode_if.sv
// Handshake bundle between the response encoder, the read FIFO and the UART transmitter.
// The master modport is the encoder; the slave modport is the FIFO/TX side.
interface uart_resp_encode_if;
  logic       rd_done;
  logic       rfifo_empty;
  logic [7:0] rfifo_data;
  logic       rfifo_rd_en;
  logic       tx_done;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       busy;
  logic       frame_done;

  modport master (
    input  rd_done, rfifo_empty, rfifo_data, tx_done,
    output rfifo_rd_en, tx_start, tx_data, busy, frame_done
  );

  modport slave (
    output rd_done, rfifo_empty, rfifo_data, tx_done,
    input  rfifo_rd_en, tx_start, tx_data, busy, frame_done
  );
endinterface

// File: rtl/uart_resp_encode.sv
// Drains SEND_NUM bytes from the read FIFO into the UART TX, paced on tx_done.
// Define RESP_HEADER_EN to prefix every frame with HDR_BYTE.
module uart_resp_encode #(
  parameter int         SEND_NUM = 4,
  parameter logic [7:0] HDR_BYTE = 8'hAA
) (
  input logic                clk,
  input logic                rst,
  uart_resp_encode_if.master bus
);

  localparam logic [7:0] LAST_IDX = 8'(SEND_NUM - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
`ifdef RESP_HEADER_EN
    S_HDR   = 3'd1,
    S_HWAIT = 3'd2,
`endif
    S_FETCH = 3'd3,
    S_LATCH = 3'd4,
    S_WAIT  = 3'd5,
    S_DONE  = 3'd6
  } state_t;

  state_t     state;
  logic [7:0] byte_cnt;
  logic       pending;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      byte_cnt        <= 8'd0;
      pending         <= 1'b0;
      bus.rfifo_rd_en <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.tx_data     <= 8'd0;
      bus.busy        <= 1'b0;
      bus.frame_done  <= 1'b0;
    end else begin
      bus.rfifo_rd_en <= 1'b0;
      bus.tx_start    <= 1'b0;
      bus.frame_done  <= 1'b0;

      // A request arriving mid-frame (including the DONE cycle) is remembered once.
      if (bus.rd_done && (state != S_IDLE))
        pending <= 1'b1;

      case (state)
        S_IDLE: begin
          byte_cnt <= 8'd0;
          if (bus.rd_done || pending) begin
            pending  <= 1'b0;
            bus.busy <= 1'b1;
`ifdef RESP_HEADER_EN
            state    <= S_HDR;
`else
            state    <= S_FETCH;
`endif
          end
        end
`ifdef RESP_HEADER_EN
        S_HDR: begin
          bus.tx_data  <= HDR_BYTE;
          bus.tx_start <= 1'b1;
          state        <= S_HWAIT;
        end
        S_HWAIT: begin
          if (bus.tx_done)
            state <= S_FETCH;
        end
`endif
        S_FETCH: begin
          if (!bus.rfifo_empty) begin
            bus.rfifo_rd_en <= 1'b1;
            state           <= S_LATCH;
          end
        end
        S_LATCH: begin
          bus.tx_data  <= bus.rfifo_data;
          bus.tx_start <= 1'b1;
          state        <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.tx_done) begin
            byte_cnt <= byte_cnt + 8'd1;
            state    <= (byte_cnt == LAST_IDX) ? S_DONE : S_FETCH;
          end
        end
        S_DONE: begin
          bus.frame_done <= 1'b1;
          bus.busy       <= 1'b0;
          byte_cnt       <= 8'd0;
          state          <= S_IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          state    <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_resp_encode.sv
// Randomized bench for uart_resp_encode: FIFO/TX models plus a frame-level reference model.
// Build with +define+RESP_HEADER_EN to exercise the header variant.
module tb_uart_resp_encode;

  localparam int         SEND_NUM = 4;
  localparam logic [7:0] HDR      = 8'hAA;
`ifdef RESP_HEADER_EN
  localparam int HDR_N = 1;
`else
  localparam int HDR_N = 0;
`endif
  localparam int FIRST_TXS = 3 - HDR_N;
  localparam int FIRST_RD  = 2 + HDR_N * 12;

  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_resp_encode_if bus();

  uart_resp_encode #(.SEND_NUM(SEND_NUM), .HDR_BYTE(HDR)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] fifo_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] sent[$];
  bit  m_busy, m_pend, hdr_inflight, chk_gap, stray_req;
  int  frames_exp, frames_seen, fb, tx_cnt, tx_lat, rd_pulses;
  int  last_txdone_cyc, last_fd_cyc, last_start_cyc, first_rd_cyc, first_txs_cyc;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model and per-cycle compare, sampled 1 time unit after each rising edge.
  initial begin : mon
    bit is_hdr;
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        if (bus.rd_done) begin
          if (!m_busy) begin m_busy = 1; frames_exp++; end
          else if (!m_pend) begin m_pend = 1; frames_exp++; end
        end
        if (bus.rfifo_rd_en) begin
          check("rd_en_while_empty", (fifo_q.size() != 0) ? 1 : 0, 1);
          check("rd_en_before_hdr_done", hdr_inflight ? 1 : 0, 0);
          if (first_rd_cyc < 0) first_rd_cyc = cyc;
          rd_pulses++;
          if (fifo_q.size() != 0) bus.rfifo_data = fifo_q.pop_front();
          bus.rfifo_empty = (fifo_q.size() == 0);
        end
        if (bus.tx_start) begin
          is_hdr = 0;
`ifdef RESP_HEADER_EN
          is_hdr = (fb == 0);
`endif
          if (fb == 0) last_start_cyc = cyc;
          if (first_txs_cyc < 0) first_txs_cyc = cyc;
          if (chk_gap && fb > 0) check("gap_after_tx_done", cyc - last_txdone_cyc, 3);
          if (is_hdr) begin
            check("hdr_byte", bus.tx_data, HDR);
            hdr_inflight = 1;
          end else if (exp_q.size() == 0) begin
            check("payload_available", 0, 1);
          end else begin
            check("payload_byte", bus.tx_data, exp_q.pop_front());
            sent.push_back(bus.tx_data);
          end
          fb++;
          tx_cnt = tx_lat + 1;
        end
        if (bus.frame_done) begin
          check("frame_bytes", fb, SEND_NUM + HDR_N);
          fb = 0;
          frames_seen++;
          last_fd_cyc = cyc;
          check("frame_expected", (frames_seen <= frames_exp) ? 1 : 0, 1);
          if (m_pend) m_pend = 0; else m_busy = 0;
          check("busy_at_frame_done", bus.busy, 0);
        end else begin
          check("busy", bus.busy, m_busy);
        end
        bus.tx_done = 1'b0;
        if (tx_cnt > 0) begin
          tx_cnt--;
          if (tx_cnt == 0) begin
            bus.tx_done     = 1'b1;
            last_txdone_cyc = cyc;
            hdr_inflight    = 0;
          end
        end else if (stray_req) begin
          bus.tx_done = 1'b1;
          stray_req   = 0;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    fifo_q.push_back(b);
    exp_q.push_back(b);
    bus.rfifo_empty = 1'b0;
  endtask

  task automatic pulse_rd();
    @(negedge clk);
    bus.rd_done = 1'b1;
    @(negedge clk);
    bus.rd_done = 1'b0;
  endtask

  task automatic wait_fb(input int target, input int budget);
    int n = 0;
    while (fb < target && n < budget) begin @(negedge clk); n++; end
    check("wait_byte_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_seen(input int target, input int budget);
    int n = 0;
    while (frames_seen < target && n < budget) begin @(negedge clk); n++; end
    check("wait_frame_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic wait_frames(input int budget);
    int n = 0;
    while ((frames_seen < frames_exp || bus.busy) && n < budget) begin @(negedge clk); n++; end
    check("drain_timeout", (n < budget) ? 1 : 0, 1);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_rd_en"},      bus.rfifo_rd_en, 0);
    check({tag, "_tx_start"},   bus.tx_start,    0);
    check({tag, "_tx_data"},    bus.tx_data,     0);
    check({tag, "_busy"},       bus.busy,        0);
    check({tag, "_frame_done"}, bus.frame_done,  0);
  endtask

  task automatic flush_fifo();
    fifo_q.delete();
    exp_q.delete();
    bus.rfifo_empty = 1'b1;
  endtask

  task automatic start_scenario();
    sent.delete();
    rd_pulses     = 0;
    first_rd_cyc  = -1;
    first_txs_cyc = -1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin : stim
    int f0, rd_cyc, fd1;
    logic [7:0] b;
    bus.rd_done = 1'b0; bus.rfifo_empty = 1'b1; bus.rfifo_data = 8'd0; bus.tx_done = 1'b0;
    tx_lat = 10; tx_cnt = 0; fb = 0; frames_exp = 0; frames_seen = 0;
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Basic frame, plus a stray tx_done while idle.
    stray_req = 1;
    repeat (4) @(negedge clk);
    start_scenario(); chk_gap = 1; f0 = frames_seen;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    @(negedge clk);
    bus.rd_done = 1'b1; rd_cyc = cyc;
    @(negedge clk);
    bus.rd_done = 1'b0;
    wait_frames(1000);
    check("basic_rd_latency", first_rd_cyc - rd_cyc, FIRST_RD);
    check("basic_tx_latency", first_txs_cyc - rd_cyc, FIRST_TXS);
    check("basic_frames", frames_seen - f0, 1);
    check("basic_rd_pulses", rd_pulses, 4);
    check("basic_count", sent.size(), 4);
    if (sent.size() == 4) begin
      check("basic_b0", sent[0], 8'h11);
      check("basic_b1", sent[1], 8'h22);
      check("basic_b2", sent[2], 8'h33);
      check("basic_b3", sent[3], 8'h44);
    end
    check("basic_busy_after", bus.busy, 0);

    // FIFO underflow with a stray tx_done during the FETCH stall.
    start_scenario(); chk_gap = 0; f0 = frames_seen;
    push(8'h11); push(8'h22);
    pulse_rd();
    repeat (45) @(negedge clk);
    stray_req = 1;
    repeat (5) @(negedge clk);
    check("stall_busy", bus.busy, 1);
    check("stall_rd_pulses", rd_pulses, 2);
    push(8'h33); push(8'h44);
    wait_frames(1000);
    check("underflow_frames", frames_seen - f0, 1);
    check("underflow_rd_pulses", rd_pulses, 4);
    check("underflow_count", sent.size(), 4);
    if (sent.size() == 4) begin
      check("underflow_b2", sent[2], 8'h33);
      check("underflow_b3", sent[3], 8'h44);
    end

    // Back-to-back: one queued request, one dropped; a spare byte stays in the FIFO.
    start_scenario(); chk_gap = 1; f0 = frames_seen;
    for (int i = 0; i < 2 * SEND_NUM + 1; i++) push(8'($urandom));
    pulse_rd();
    wait_fb(HDR_N + 2, 200);
    pulse_rd();
    repeat (3) @(negedge clk);
    pulse_rd();
    wait_seen(f0 + 1, 1000);
    fd1 = last_fd_cyc;
    wait_fb(1, 50);
    check("b2b_restart_latency", last_start_cyc - fd1, FIRST_TXS);
    wait_frames(2000);
    check("b2b_frames", frames_seen - f0, 2);
    check("b2b_count", sent.size(), 2 * SEND_NUM);
    check("b2b_rd_pulses", rd_pulses, 2 * SEND_NUM);
    check("b2b_fifo_left", fifo_q.size(), 1);
    flush_fifo();

    // Reset mid-frame.
    start_scenario(); chk_gap = 0; f0 = frames_seen;
    for (int i = 0; i < SEND_NUM; i++) push(8'($urandom));
    pulse_rd();
    wait_fb(2, 200);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_outputs_zero("midreset");
    flush_fifo();
    tx_cnt = 0; bus.tx_done = 1'b0; fb = 0; m_busy = 0; m_pend = 0;
    hdr_inflight = 0; stray_req = 0; frames_exp = frames_seen;
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("midreset_no_frame_done", frames_seen - f0, 0);
    start_scenario();
    for (int i = 0; i < SEND_NUM; i++) push(8'($urandom));
    pulse_rd();
    wait_frames(1000);
    check("after_reset_frames", frames_seen - f0, 1);
    check("after_reset_count", sent.size(), SEND_NUM);
    check("after_reset_rd_pulses", rd_pulses, SEND_NUM);

    // Random frames: random data, TX latency and FIFO fill timing.
    for (int k = 0; k < 6; k++) begin
      int pre;
      start_scenario(); chk_gap = 0; f0 = frames_seen;
      tx_lat = $urandom_range(2, 14);
      pre = $urandom_range(0, SEND_NUM);
      for (int i = 0; i < pre; i++) push(8'($urandom));
      pulse_rd();
      for (int i = pre; i < SEND_NUM; i++) begin
        repeat ($urandom_range(0, 20)) @(negedge clk);
        b = 8'($urandom);
        push(b);
      end
      wait_frames(2000);
      check("rand_frames", frames_seen - f0, 1);
      check("rand_count", sent.size(), SEND_NUM);
      check("rand_fifo_drained", fifo_q.size(), 0);
    end

    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
